// File: rtl/tlul_dma_pkg.sv
// tlul_dma_pkg: state encoding and constants of the TL-UL word-copy engine.
package tlul_dma_pkg;
   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_RSP,
      WR_REQ,
      WR_RSP,
      DONE
   } dma_state_e;
   localparam int unsigned DmaWordBytes = 4;
endpackage

// File: rtl/tlul_pkg.sv
// tlul_pkg: TL-UL channel types, opcodes and widths shared by hosts and devices.
package tlul_pkg;
   localparam int TL_AW  = 32;
   localparam int TL_DW  = 32;
   localparam int TL_AIW = 8;
   localparam int TL_SZW = 2;
   localparam int TL_DBW = 4;
   typedef enum logic [2:0] {
      PutFullData    = 3'h0,
      PutPartialData = 3'h1,
      Get            = 3'h4
   } tl_a_op_e;
   typedef enum logic [2:0] {
      AccessAck     = 3'h0,
      AccessAckData = 3'h1
   } tl_d_op_e;
   typedef struct packed {
      logic [6:0] rsvd;
      logic [3:0] instr_type;
   } tl_a_user_t;
   localparam tl_a_user_t TL_A_USER_DEFAULT = '{rsvd: 7'h0, instr_type: 4'h9};
   typedef struct packed {
      logic              a_valid;
      tl_a_op_e          a_opcode;
      logic [2:0]        a_param;
      logic [TL_SZW-1:0] a_size;
      logic [TL_AIW-1:0] a_source;
      logic [TL_AW-1:0]  a_address;
      logic [TL_DBW-1:0] a_mask;
      logic [TL_DW-1:0]  a_data;
      tl_a_user_t        a_user;
      logic              d_ready;
   } tl_h2d_t;
   typedef struct packed {
      logic              d_valid;
      tl_d_op_e          d_opcode;
      logic [2:0]        d_param;
      logic [TL_SZW-1:0] d_size;
      logic [TL_AIW-1:0] d_source;
      logic              d_sink;
      logic [TL_DW-1:0]  d_data;
      logic              d_error;
      logic              a_ready;
   } tl_d2h_t;
endpackage

// File: rtl/tlul_dma_copy.sv
// tlul_dma_copy: TL-UL host that copies len_i words from src to dst, one transaction at a time.
module tlul_dma_copy
   import tlul_pkg::*;
   import tlul_dma_pkg::*;
#(
   parameter logic [TL_AIW-1:0] SrcId = '0,
   parameter int                LenW  = 16
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            start_i,
   input  logic [31:0]     src_addr_i,
   input  logic [31:0]     dst_addr_i,
   input  logic [LenW-1:0] len_i,
   output logic            busy_o,
   output logic            done_o,
   output logic            err_o,
   output tl_h2d_t         tl_o,
   input  tl_d2h_t         tl_i
);
   dma_state_e      state_q, state_d;
   logic [31:0]     src_q, src_d, dst_q, dst_d, data_q, data_d;
   logic [LenW-1:0] cnt_q, cnt_d;
   logic            err_q, err_d;
   logic            rsp, rsp_bad, misaligned;
   logic            unused_d;

   assign rsp        = tl_i.d_valid && tl_i.d_source == SrcId;
   assign rsp_bad    = tl_i.d_error || tl_i.d_opcode != (state_q == RD_RSP ? AccessAckData : AccessAck);
   assign misaligned = |{src_addr_i[1:0], dst_addr_i[1:0]};
   assign unused_d   = ^{tl_i.d_param, tl_i.d_size, tl_i.d_sink};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Responses are only looked at in the *_RSP states, so one arriving with
   // the request handshake or after a reset falls through untouched.
   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: if (start_i) begin
            src_d   = src_addr_i;
            dst_d   = dst_addr_i;
            cnt_d   = len_i;
            err_d   = misaligned;
            state_d = (misaligned || len_i == '0) ? DONE : RD_REQ;
         end
         RD_REQ: if (tl_i.a_ready) state_d = RD_RSP;
         RD_RSP: if (rsp) begin
            err_d   = err_q | rsp_bad;
            data_d  = tl_i.d_data;
            state_d = rsp_bad ? DONE : WR_REQ;
         end
         WR_REQ: if (tl_i.a_ready) state_d = WR_RSP;
         WR_RSP: if (rsp) begin
            err_d   = err_q | rsp_bad;
            src_d   = rsp_bad ? src_q : src_q + 32'(DmaWordBytes);
            dst_d   = rsp_bad ? dst_q : dst_q + 32'(DmaWordBytes);
            cnt_d   = rsp_bad ? cnt_q : cnt_q - LenW'(1);
            state_d = (rsp_bad || cnt_q == LenW'(1)) ? DONE : RD_REQ;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign busy_o = state_q != IDLE;
   assign done_o = state_q == DONE;
   assign err_o  = err_q;

   always_comb begin
      tl_o           = '0;
      tl_o.a_valid   = state_q inside {RD_REQ, WR_REQ};
      tl_o.a_opcode  = state_q == WR_REQ ? PutFullData : Get;
      tl_o.a_param   = 3'h0;
      tl_o.a_size    = TL_SZW'(2);
      tl_o.a_source  = SrcId;
      tl_o.a_address = state_q == WR_REQ ? dst_q : src_q;
      tl_o.a_mask    = 4'hF;
      tl_o.a_data    = state_q == WR_REQ ? data_q : '0;
      tl_o.a_user    = TL_A_USER_DEFAULT;
      tl_o.d_ready   = 1'b1;
   end
endmodule

// File: tb/tb_tlul_dma_copy.sv
// tb_tlul_dma_copy: directed bench with a two-cycle-latency memory device behind the TL-UL port.
module tb_tlul_dma_copy;
   import tlul_pkg::*;
   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic [31:0] src = '0, dst = '0;
   logic [15:0] len = '0;
   logic        busy, done, err;
   tl_h2d_t     tl_o;
   tl_d2h_t     tl_i;
   int checks = 0, errors = 0;
   int stall = 0, err_at = 0, stray_at = 0;
   int ngets = 0, stall_cycles = 0, dv_cycles = 0;
   tl_a_op_e    op_log[$];
   logic [31:0] addr_log[$], data_log[$];
   logic [31:0] mem [logic [31:0]];

   tlul_dma_copy dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .src_addr_i(src), .dst_addr_i(dst),
      .len_i(len), .busy_o(busy), .done_o(done), .err_o(err), .tl_o(tl_o), .tl_i(tl_i)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : ~a;
   endfunction

   // Device: samples the A handshake mid-cycle, answers two cycles after acceptance.
   initial begin
      logic hs, pend, r_err;
      tl_d_op_e r_op;
      logic [31:0] r_data;
      int wcnt;
      tl_i = '0;
      pend = 0; wcnt = 0; r_err = 0; r_op = AccessAck; r_data = '0;
      forever begin
         @(negedge clk);
         hs = tl_o.a_valid && tl_i.a_ready;
         if (tl_o.a_valid && !tl_i.a_ready) stall_cycles++;
         if (tl_i.d_valid) dv_cycles++;
         if (hs) begin
            op_log.push_back(tl_o.a_opcode);
            addr_log.push_back(tl_o.a_address);
            data_log.push_back(tl_o.a_data);
            if (tl_o.a_opcode == Get) begin
               ngets++;
               r_op = AccessAckData; r_data = rd(tl_o.a_address); r_err = (ngets == err_at);
            end else begin
               mem[tl_o.a_address] = tl_o.a_data;
               r_op = AccessAck; r_data = '0; r_err = 0;
            end
         end
         @(posedge clk); #1;
         tl_i.d_valid = 0; tl_i.d_error = 0; tl_i.d_source = '0; tl_i.d_data = '0; tl_i.d_opcode = AccessAck;
         if (pend) begin
            tl_i.d_valid = 1; tl_i.d_opcode = r_op; tl_i.d_data = r_data; tl_i.d_error = r_err; pend = 0;
         end
         if (hs) begin
            pend = 1;
            if (r_op == AccessAckData && ngets == stray_at) begin
               tl_i.d_valid = 1; tl_i.d_source = 8'h05; tl_i.d_opcode = AccessAck;
               tl_i.d_data = 32'hBAD0BAD0; tl_i.d_error = 1;
            end
         end
         if (hs || !rst_n) wcnt = 0;
         tl_i.a_ready = !(tl_o.a_valid && wcnt < stall);
         if (tl_o.a_valid && wcnt < stall) wcnt++;
      end
   end

   task automatic run_copy(input logic [31:0] s, d, input logic [15:0] n, input int repulse,
                           output int done_cyc, output int done_cnt, output int av_cyc, output int unstable);
      tl_h2d_t prev;
      logic pstall;
      done_cyc = -1; done_cnt = 0; av_cyc = 0; unstable = 0; pstall = 0; prev = '0;
      @(negedge clk);
      src = s; dst = d; len = n; start = 1;
      for (int c = 1; c <= 2000; c++) begin
         @(negedge clk);
         start = (c == repulse);
         if (c == repulse) begin src = 32'h9000; dst = 32'h9800; end
         if (pstall && tl_o !== prev) unstable++;
         pstall = tl_o.a_valid && !tl_i.a_ready;
         prev = tl_o;
         if (tl_o.a_valid) av_cyc++;
         if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = c; end
         if (done_cyc >= 0 && c >= done_cyc + 2) break;
      end
      start = 0;
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
      checks++; if (tl_o.a_valid !== 1'b0) begin errors++; $display("FAIL rst_a_valid got %b exp 0", tl_o.a_valid); end
      rst_n = 1;
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", done); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", err); end
      checks++; if (tl_o.d_ready !== 1'b1) begin errors++; $display("FAIL rst_d_ready got %b exp 1", tl_o.d_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", busy); end
   endtask

   task automatic test_basic;
      int dc, dn, av, un, base;
      logic [31:0] ea;
      base = op_log.size();
      run_copy(32'h1000, 32'h2000, 3, 2, dc, dn, av, un);
      checks++; if (dc !== 19) begin errors++; $display("FAIL basic_done_cyc got %0d exp 19", dc); end
      checks++; if (dn !== 1) begin errors++; $display("FAIL basic_done_width got %0d exp 1", dn); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL basic_err got %b exp 0", err); end
      checks++; if (av !== 6) begin errors++; $display("FAIL basic_a_valid_cycles got %0d exp 6", av); end
      checks++; if (op_log.size() - base !== 6) begin errors++; $display("FAIL basic_txn_count got %0d exp 6", op_log.size() - base); end
      for (int i = 0; i < op_log.size() - base; i++) begin
         ea = (i % 2 == 0) ? 32'h1000 + 32'(4 * (i / 2)) : 32'h2000 + 32'(4 * (i / 2));
         checks++; if (op_log[base+i] !== ((i % 2 == 0) ? Get : PutFullData)) begin errors++; $display("FAIL basic_op[%0d] got %0d", i, op_log[base+i]); end
         checks++; if (addr_log[base+i] !== ea) begin errors++; $display("FAIL basic_addr[%0d] got %h exp %h", i, addr_log[base+i], ea); end
         if (i % 2 == 1) begin
            checks++; if (data_log[base+i] !== ~(ea - 32'h1000)) begin errors++; $display("FAIL basic_put_data[%0d] got %h exp %h", i, data_log[base+i], ~(ea - 32'h1000)); end
         end
      end
      checks++; if (rd(32'h2008) !== 32'hFFFF_EFF7) begin errors++; $display("FAIL basic_mem_2008 got %h exp ffffeff7", rd(32'h2008)); end
   endtask

   task automatic test_backpressure;
      int dc, dn, av, un, sc0;
      sc0 = stall_cycles;
      stall = 5;
      run_copy(32'h3000, 32'h4000, 2, 0, dc, dn, av, un);
      stall = 0;
      checks++; if (dc !== 33) begin errors++; $display("FAIL bp_done_cyc got %0d exp 33", dc); end
      checks++; if (un !== 0) begin errors++; $display("FAIL bp_a_stable got %0d changes exp 0", un); end
      checks++; if (stall_cycles - sc0 !== 20) begin errors++; $display("FAIL bp_stall_cycles got %0d exp 20", stall_cycles - sc0); end
      checks++; if (av !== 24) begin errors++; $display("FAIL bp_a_valid_cycles got %0d exp 24", av); end
      checks++; if (rd(32'h4004) !== ~32'h3004) begin errors++; $display("FAIL bp_mem got %h exp %h", rd(32'h4004), ~32'h3004); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL bp_err got %b exp 0", err); end
   endtask

   task automatic test_error;
      int dc, dn, av, un, base, puts, gets;
      base = op_log.size(); puts = 0; gets = 0;
      err_at = ngets + 2;
      run_copy(32'h1100, 32'h2100, 4, 0, dc, dn, av, un);
      for (int i = base; i < op_log.size(); i++) if (op_log[i] == PutFullData) puts++; else gets++;
      checks++; if (puts !== 1) begin errors++; $display("FAIL err_puts got %0d exp 1", puts); end
      checks++; if (gets !== 2) begin errors++; $display("FAIL err_gets got %0d exp 2", gets); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_flag got %b exp 1", err); end
      checks++; if (dc !== 10) begin errors++; $display("FAIL err_done_cyc got %0d exp 10", dc); end
      checks++; if (dn !== 1) begin errors++; $display("FAIL err_done_width got %0d exp 1", dn); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL err_idle got %b exp 0", busy); end
   endtask

   task automatic test_misaligned_zero;
      int dc, dn, av, un, base;
      base = op_log.size();
      run_copy(32'h1002, 32'h2000, 2, 0, dc, dn, av, un);
      checks++; if (av !== 0) begin errors++; $display("FAIL mis_a_valid got %0d exp 0", av); end
      checks++; if (dc !== 1) begin errors++; $display("FAIL mis_done_cyc got %0d exp 1", dc); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL mis_err got %b exp 1", err); end
      run_copy(32'h1000, 32'h2000, 0, 0, dc, dn, av, un);
      checks++; if (av !== 0) begin errors++; $display("FAIL zero_a_valid got %0d exp 0", av); end
      checks++; if (dc !== 1) begin errors++; $display("FAIL zero_done_cyc got %0d exp 1", dc); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL zero_err got %b exp 0", err); end
      run_copy(32'h1000, 32'h2001, 1, 0, dc, dn, av, un);
      checks++; if (err !== 1'b1 || av !== 0) begin errors++; $display("FAIL mis_dst got err %b av %0d exp 1 0", err, av); end
      checks++; if (op_log.size() !== base) begin errors++; $display("FAIL mis_txn_count got %0d exp %0d", op_log.size(), base); end
   endtask

   task automatic test_wrap;
      int dc, dn, av, un, base;
      base = op_log.size();
      run_copy(32'hFFFF_FFFC, 32'h5000, 2, 0, dc, dn, av, un);
      checks++; if (dc !== 13) begin errors++; $display("FAIL wrap_done_cyc got %0d exp 13", dc); end
      checks++; if (addr_log[base+2] !== 32'h0) begin errors++; $display("FAIL wrap_addr got %h exp 00000000", addr_log[base+2]); end
      checks++; if (rd(32'h5004) !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_data got %h exp ffffffff", rd(32'h5004)); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL wrap_err got %b exp 0", err); end
   endtask

   task automatic test_source_filter;
      int dc, dn, av, un, dv0;
      dv0 = dv_cycles;
      stray_at = ngets + 1;
      run_copy(32'h6000, 32'h7000, 1, 0, dc, dn, av, un);
      checks++; if (dv_cycles - dv0 !== 3) begin errors++; $display("FAIL src_d_valid_count got %0d exp 3", dv_cycles - dv0); end
      checks++; if (dc !== 7) begin errors++; $display("FAIL src_done_cyc got %0d exp 7", dc); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL src_err got %b exp 0", err); end
      checks++; if (rd(32'h7000) !== ~32'h6000) begin errors++; $display("FAIL src_mem got %h exp %h", rd(32'h7000), ~32'h6000); end
   endtask

   task automatic test_reset_mid;
      int dc, dn, av, un, dv0, bad;
      logic found;
      found = 0; bad = 0;
      @(negedge clk);
      src = 32'h8000; dst = 32'h8800; len = 2; start = 1;
      for (int c = 1; c <= 50 && !found; c++) begin
         @(negedge clk);
         start = 0;
         found = tl_o.a_valid && tl_o.a_opcode == PutFullData && tl_i.a_ready;
      end
      checks++; if (!found) begin errors++; $display("FAIL rmid_wr_req got 0 exp 1"); end
      #1 rst_n = 0;
      #1;
      checks++; if (tl_o.a_valid !== 1'b0) begin errors++; $display("FAIL rmid_a_valid got %b exp 0", tl_o.a_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", busy); end
      @(negedge clk);
      rst_n = 1;
      dv0 = dv_cycles;
      repeat (4) begin
         @(negedge clk);
         if (busy || done || tl_o.a_valid) bad++;
      end
      checks++; if (dv_cycles - dv0 !== 1) begin errors++; $display("FAIL rmid_late_rsp got %0d exp 1", dv_cycles - dv0); end
      checks++; if (bad !== 0) begin errors++; $display("FAIL rmid_ignored got %0d active cycles exp 0", bad); end
      run_copy(32'h8100, 32'h8900, 1, 0, dc, dn, av, un);
      checks++; if (dc !== 7) begin errors++; $display("FAIL rmid_next_done got %0d exp 7", dc); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL rmid_next_err got %b exp 0", err); end
      checks++; if (rd(32'h8900) !== ~32'h8100) begin errors++; $display("FAIL rmid_next_mem got %h exp %h", rd(32'h8900), ~32'h8100); end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_backpressure;
      test_error;
      test_misaligned_zero;
      test_wrap;
      test_source_filter;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
